// File: rtl/packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_SRC Avalon-ST sinks into
// one registered Avalon-ST source; a grant is held from sop through eop.
//
// Ports:
//   clk_i, arst_n_i            clock, asynchronous active-low reset
//   sink_*_i / sink_ready_o    NUM_SRC packed sink streams (port k = slice k)
//   src_*_o / src_ready_i      merged registered source stream
//   src_id_o                   index of the port that sourced the output word
//   drop_cnt_o                 flushed orphan-word counter, present only when
//                              PKT_RR_ARBITER_DROP_CNT_EN is defined
module packet_rr_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH/8),
    parameter int ID_WIDTH      = $clog2(NUM_SRC)
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic [NUM_SRC*AST_DWIDTH-1:0]    sink_data_i,
    input  logic [NUM_SRC-1:0]               sink_valid_i,
    input  logic [NUM_SRC-1:0]               sink_startofpacket_i,
    input  logic [NUM_SRC-1:0]               sink_endofpacket_i,
    input  logic [NUM_SRC*EMPTY_WIDTH-1:0]   sink_empty_i,
    input  logic [NUM_SRC*CHANNEL_WIDTH-1:0] sink_channel_i,
    output logic [NUM_SRC-1:0]               sink_ready_o,
    input  logic                             src_ready_i,
    output logic [AST_DWIDTH-1:0]            src_data_o,
    output logic                             src_valid_o,
    output logic                             src_startofpacket_o,
    output logic                             src_endofpacket_o,
    output logic [EMPTY_WIDTH-1:0]           src_empty_o,
    output logic [CHANNEL_WIDTH-1:0]         src_channel_o,
`ifdef PKT_RR_ARBITER_DROP_CNT_EN
    output logic [15:0]                      drop_cnt_o,
`endif
    output logic [ID_WIDTH-1:0]              src_id_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]      gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]      gnt_inc;
    logic [ID_WIDTH-1:0]      pick;
    logic                     found;
    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC-1:0]       flush;
    logic                     ld;
    logic                     acc;

    logic                     sel_valid;
    logic                     sel_sop;
    logic                     sel_eop;
    logic [AST_DWIDTH-1:0]    sel_data;
    logic [EMPTY_WIDTH-1:0]   sel_empty;
    logic [CHANNEL_WIDTH-1:0] sel_channel;

    logic [AST_DWIDTH-1:0]    data_q;
    logic                     valid_q;
    logic                     sop_q;
    logic                     eop_q;
    logic [EMPTY_WIDTH-1:0]   empty_q;
    logic [CHANNEL_WIDTH-1:0] channel_q;
    logic [ID_WIDTH-1:0]      id_q;

    assign ld    = !valid_q || src_ready_i;
    assign req   = sink_valid_i & sink_startofpacket_i;
    assign flush = (state_q == ST_IDLE) ?
                   (sink_valid_i & ~sink_startofpacket_i) : '0;

    assign sel_valid   = sink_valid_i[gnt_q];
    assign sel_sop     = sink_startofpacket_i[gnt_q];
    assign sel_eop     = sink_endofpacket_i[gnt_q];
    assign sel_data    = sink_data_i[int'(gnt_q)*AST_DWIDTH +: AST_DWIDTH];
    assign sel_empty   = sink_empty_i[int'(gnt_q)*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign sel_channel =
        sink_channel_i[int'(gnt_q)*CHANNEL_WIDTH +: CHANNEL_WIDTH];

    assign acc = (state_q == ST_BUSY) && sel_valid && ld;

    // Explicit wrap keeps the increment inside 0..NUM_SRC-1 for any NUM_SRC.
    assign gnt_inc = (gnt_q == ID_WIDTH'(NUM_SRC-1)) ?
                     '0 : gnt_q + ID_WIDTH'(1);

    // Round-robin scan starting at ptr, wrapping modulo NUM_SRC.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(j);
            end
        end
    end

    always_comb begin
        sink_ready_o = '0;
        if (state_q == ST_IDLE) begin
            sink_ready_o = flush;
        end else begin
            sink_ready_o[gnt_q] = ld;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (acc && sel_eop) begin
                    state_d = ST_IDLE;
                    ptr_d   = gnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            empty_q   <= '0;
            channel_q <= '0;
            id_q      <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            if (acc) begin
                data_q    <= sel_data;
                valid_q   <= 1'b1;
                sop_q     <= sel_sop;
                eop_q     <= sel_eop;
                empty_q   <= sel_empty;
                channel_q <= sel_channel;
                id_q      <= gnt_q;
            end else if (ld) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef PKT_RR_ARBITER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [4:0]  n_flush;
    logic [16:0] drop_sum;

    always_comb begin
        n_flush = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            n_flush = n_flush + 5'(flush[k]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_flush);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign src_data_o          = data_q;
    assign src_valid_o         = valid_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o   = eop_q;
    assign src_empty_o         = empty_q;
    assign src_channel_o       = channel_q;
    assign src_id_o            = id_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Testbench for packet_rr_arbiter: directed packets per port, expected words
// queued up front in hand-computed order, independent output monitor.
module tb_packet_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 1;
    localparam int EW = 3;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] emp;
        logic [CW-1:0] ch;
        logic [IW-1:0] id;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [DW-1:0] d   [N];
    logic          v   [N];
    logic          sop [N];
    logic          eop [N];
    logic [EW-1:0] emp [N];
    logic [CW-1:0] ch  [N];

    logic [N*DW-1:0] sink_data;
    logic [N-1:0]    sink_valid;
    logic [N-1:0]    sink_sop;
    logic [N-1:0]    sink_eop;
    logic [N*EW-1:0] sink_empty;
    logic [N*CW-1:0] sink_channel;
    logic [N-1:0]    sink_ready_o;
    logic            src_ready_i;
    logic [DW-1:0]   src_data_o;
    logic            src_valid_o;
    logic            src_startofpacket_o;
    logic            src_endofpacket_o;
    logic [EW-1:0]   src_empty_o;
    logic [CW-1:0]   src_channel_o;
    logic [IW-1:0]   src_id_o;
`ifdef PKT_RR_ARBITER_DROP_CNT_EN
    logic [15:0]     drop_cnt_o;
`endif

    word_t exp_q[$];
    int    obs_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    n_obs  = 0;
    logic  mon_en = 1'b0;

    always_comb begin
        sink_data    = '0;
        sink_valid   = '0;
        sink_sop     = '0;
        sink_eop     = '0;
        sink_empty   = '0;
        sink_channel = '0;
        for (int k = 0; k < N; k++) begin
            sink_data[k*DW +: DW]    = d[k];
            sink_valid[k]            = v[k];
            sink_sop[k]              = sop[k];
            sink_eop[k]              = eop[k];
            sink_empty[k*EW +: EW]   = emp[k];
            sink_channel[k*CW +: CW] = ch[k];
        end
    end

    packet_rr_arbiter #(
        .NUM_SRC(N), .AST_DWIDTH(DW), .CHANNEL_WIDTH(CW),
        .EMPTY_WIDTH(EW), .ID_WIDTH(IW)
    ) dut (
        .clk_i               (clk),
        .arst_n_i            (rst_n),
        .sink_data_i         (sink_data),
        .sink_valid_i        (sink_valid),
        .sink_startofpacket_i(sink_sop),
        .sink_endofpacket_i  (sink_eop),
        .sink_empty_i        (sink_empty),
        .sink_channel_i      (sink_channel),
        .sink_ready_o        (sink_ready_o),
        .src_ready_i         (src_ready_i),
        .src_data_o          (src_data_o),
        .src_valid_o         (src_valid_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_empty_o         (src_empty_o),
        .src_channel_o       (src_channel_o),
`ifdef PKT_RR_ARBITER_DROP_CNT_EN
        .drop_cnt_o          (drop_cnt_o),
`endif
        .src_id_o            (src_id_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mk(input int p, input int w);
        return 64'hD000_0000_0000_0000 | (64'(p) << 8) | 64'(w);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_pkt(input int p, input int n, input int e,
                            input bit s, input bit le);
        word_t x;
        for (int w = 0; w < n; w++) begin
            x.data = mk(p, w);
            x.sop  = s && (w == 0);
            x.eop  = le && (w == n - 1);
            x.emp  = x.eop ? EW'(e) : '0;
            x.ch   = CW'(p);
            x.id   = IW'(p);
            exp_q.push_back(x);
        end
    endtask

    task automatic drive(input int p, input int n, input int e,
                         input bit s, input bit le,
                         output int waits, output int first);
        int k;
        waits = 0;
        first = 0;
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            if (w == 0) first = cyc;
            d[p]   = mk(p, w);
            v[p]   = 1'b1;
            sop[p] = s && (w == 0);
            eop[p] = le && (w == n - 1);
            emp[p] = eop[p] ? EW'(e) : '0;
            ch[p]  = CW'(p);
            #1;
            k = 0;
            while (!sink_ready_o[p] && k < 200) begin
                @(negedge clk);
                #1;
                k++;
            end
            waits += k;
            if (k >= 200) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout port=%0d actual=stuck required=ready", p);
            end
        end
        @(negedge clk);
        v[p]   = 1'b0;
        sop[p] = 1'b0;
        eop[p] = 1'b0;
    endtask

    // Output monitor: compares every transferred word against the queue.
    always begin
        word_t got;
        word_t e;
        @(negedge clk);
        #2;
        if (mon_en && src_valid_o && src_ready_i) begin
            got = {src_data_o, src_startofpacket_o, src_endofpacket_o,
                   src_empty_o, src_channel_o, src_id_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL word actual=%0h required=%0h", got, e);
                end
            end
            n_obs++;
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt, f0, f1, f2, base, k;
        for (int i = 0; i < N; i++) begin
            d[i] = '0; v[i] = 1'b0; sop[i] = 1'b0;
            eop[i] = 1'b0; emp[i] = '0; ch[i] = '0;
        end
        src_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(src_valid_o), 64'd0);
        chk("rst_ready", 64'(sink_ready_o), 64'd0);
        chk("rst_data", src_data_o, 64'd0);
        chk("rst_sop_eop", 64'({src_startofpacket_o, src_endofpacket_o}), 64'd0);
        chk("rst_id", 64'(src_id_o), 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // single port 2, 3 words, empty 3
        obs_cyc.delete();
        push_pkt(2, 3, 3, 1'b1, 1'b1);
        drive(2, 3, 3, 1'b1, 1'b1, wt, f0);
        repeat (3) @(negedge clk);
        chk("t1_count", 64'(obs_cyc.size()), 64'd3);
        if (obs_cyc.size() == 3) begin
            chk("t1_lat_w0", 64'(obs_cyc[0]), 64'(f0 + 2));
            chk("t1_lat_w1", 64'(obs_cyc[1]), 64'(f0 + 3));
            chk("t1_lat_w2", 64'(obs_cyc[2]), 64'(f0 + 4));
        end

        // ptr is 3: port 3 single-word beats port 0, then ptr wraps to 0
        push_pkt(3, 1, 5, 1'b1, 1'b1);
        push_pkt(0, 2, 1, 1'b1, 1'b1);
        fork
            drive(3, 1, 5, 1'b1, 1'b1, wt, f1);
            drive(0, 2, 1, 1'b1, 1'b1, wt, f2);
        join
        repeat (3) @(negedge clk);

        // backpressure on port 1 mid-packet
        push_pkt(1, 4, 2, 1'b1, 1'b1);
        fork
            drive(1, 4, 2, 1'b1, 1'b1, wt, f0);
            begin
                base = n_obs;
                k = 0;
                while (n_obs < base + 2 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_reached", 64'(k < 100), 64'd1);
                src_ready_i = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    #3;
                    chk("bp_valid", 64'(src_valid_o), 64'd1);
                    chk("bp_data", src_data_o, mk(1, 2));
                    chk("bp_sink_ready", 64'(sink_ready_o[1]), 64'd0);
                    @(negedge clk);
                end
                src_ready_i = 1'b1;
            end
        join
        repeat (3) @(negedge clk);

        // orphans on port 1 flushed in IDLE
        base = n_obs;
        drive(1, 5, 0, 1'b0, 1'b0, wt, f0);
        chk("orph_waits", 64'(wt), 64'd0);
        repeat (3) @(negedge clk);
        chk("orph_no_out", 64'(n_obs - base), 64'd0);
        chk("orph_valid", 64'(src_valid_o), 64'd0);
`ifdef PKT_RR_ARBITER_DROP_CNT_EN
        chk("drop_cnt", 64'(drop_cnt_o), 64'd5);
`endif

        // reset after 2 of 4 words on port 2
        push_pkt(2, 2, 0, 1'b1, 1'b0);
        drive(2, 2, 0, 1'b1, 1'b0, wt, f0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(src_valid_o), 64'd0);
        chk("mid_rst_ready", 64'(sink_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // contention 0,1,3 with ptr 0
        obs_cyc.delete();
        push_pkt(0, 3, 4, 1'b1, 1'b1);
        push_pkt(1, 3, 6, 1'b1, 1'b1);
        push_pkt(3, 3, 7, 1'b1, 1'b1);
        fork
            drive(0, 3, 4, 1'b1, 1'b1, wt, f0);
            drive(1, 3, 6, 1'b1, 1'b1, wt, f1);
            drive(3, 3, 7, 1'b1, 1'b1, wt, f2);
        join
        repeat (3) @(negedge clk);
        chk("ct_count", 64'(obs_cyc.size()), 64'd9);
        if (obs_cyc.size() == 9) begin
            chk("ct_tput", 64'(obs_cyc[1] - obs_cyc[0]), 64'd1);
            chk("ct_gap01", 64'(obs_cyc[3] - obs_cyc[2]), 64'd2);
            chk("ct_gap13", 64'(obs_cyc[6] - obs_cyc[5]), 64'd2);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
